stream_mux_arb: RTL and testbench

- Parametrised, registered N:1 datapath multiplexer with valid/ready handshake on every input and on the output.
- Successor to the combinational 64-bit 2:1 mux in the pipelined datapath.
- Selects by explicit select (MODE 0) or by round-robin arbitration (MODE 1).
- Holds the selection for a whole multi-beat packet (delimited by last) and registers the output, giving one pipeline stage.

---
 rtl/stream_mux_arb.sv | 124 ++++++++++++
 tb/tb_stream_mux_arb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_arb.sv
// Registered N:1 stream multiplexer with valid/ready handshakes.
// Selection is explicit (sel) or round-robin, and is held for a whole packet.
module stream_mux_arb #(
    parameter int WIDTH  = 64,
    parameter int NUM_IN = 4,
    parameter int MODE   = 0,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN-1:0]       in_last,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [SEL_W-1:0]        out_src,
    input  logic                    out_ready
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] lock_idx;
    logic [SEL_W-1:0] rr_ptr;

    logic [SEL_W-1:0] grant;
    logic             grant_ok;
    logic             found;
    int               rr_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             gnt_last;
    logic             can_load;
    logic             xfer;

    assign can_load = !out_valid || out_ready;
    assign xfer     = grant_ok && can_load && !reset;

    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        found    = 1'b0;
        rr_idx   = 0;
        if (state == LOCKED) begin
            grant    = lock_idx;
            grant_ok = in_valid[lock_idx];
        end else if (MODE == 0) begin
            grant = sel;
            if (32'(sel) < NUM_IN) begin
                grant_ok = in_valid[sel];
            end
        end else begin
            // Search starts just past the last packet's owner, wrapping round.
            for (int k = 1; k <= NUM_IN; k++) begin
                rr_idx = (int'(rr_ptr) + k) % NUM_IN;
                if (!found && in_valid[rr_idx]) begin
                    grant = SEL_W'(rr_idx);
                    found = 1'b1;
                end
            end
            grant_ok = |in_valid;
        end
    end

    always_comb begin
        gnt_data = '0;
        gnt_last = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (SEL_W'(i) == grant) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
                gnt_last = in_last[i];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready = NUM_IN'(1) << grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lock_idx  <= '0;
            rr_ptr    <= SEL_W'(NUM_IN - 1);
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (xfer) begin
            out_data  <= gnt_data;
            out_last  <= gnt_last;
            out_src   <= grant;
            out_valid <= 1'b1;
            if (gnt_last) begin
                rr_ptr <= grant;
            end
            unique case (state)
                IDLE: begin
                    if (!gnt_last) begin
                        state    <= LOCKED;
                        lock_idx <= grant;
                    end
                end
                LOCKED: begin
                    if (gnt_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: one explicit-select and one
// round-robin instance share the same stimulus.
module tb_stream_mux_arb;

    localparam int W = 64;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [1:0]     sel;
    logic           out_ready;

    logic [N-1:0]   rdy0, rdy1;
    logic [W-1:0]   od0, od1;
    logic           ov0, ov1, ol0, ol1;
    logic [1:0]     os0, os1;

    int n_chk = 0;
    int n_fail = 0;
    int cnt_in = 0;
    int cnt_out = 0;
    int in0, out0;

    always #5 clk = ~clk;

    stream_mux_arb #(.WIDTH(W), .NUM_IN(N), .MODE(0)) u0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rdy0), .sel(sel), .out_data(od0),
        .out_valid(ov0), .out_last(ol0), .out_src(os0), .out_ready(out_ready)
    );

    stream_mux_arb #(.WIDTH(W), .NUM_IN(N), .MODE(1)) u1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(rdy1), .sel(sel), .out_data(od1),
        .out_valid(ov1), .out_last(ol1), .out_src(os1), .out_ready(out_ready)
    );

    always @(posedge clk) begin
        if (|rdy1) cnt_in <= cnt_in + 1;
        if (ov1 && out_ready) cnt_out <= cnt_out + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        sel       = 2'd0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 64'h1000 + 64'(i);

        // Reset held for two cycles with everything valid
        #1;
        chk("rst_rdy0", 64'(rdy0), 64'h0);
        chk("rst_rdy1", 64'(rdy1), 64'h0);
        tick();
        tick();
        chk("rst_rdy1_b", 64'(rdy1), 64'h0);
        chk("rst_ov", 64'(ov1), 64'h0);
        chk("rst_od", od1, 64'h0);
        chk("rst_ol", 64'(ol1), 64'h0);
        chk("rst_os", 64'(os1), 64'h0);
        reset = 1'b0;
        #1;
        chk("rr_first_rdy", 64'(rdy1), 64'h1);
        tick();
        in_valid = 4'h0;
        chk("rr_first_src", 64'(os1), 64'h0);
        chk("rr_first_ov", 64'(ov1), 64'h1);
        tick();
        chk("drain_ov", 64'(ov1), 64'h0);

        // Explicit select, single beat from channel 2
        sel = 2'd2;
        in_valid = 4'b0100;
        in_data[2*W +: W] = 64'hDEAD_BEEF_0000_0002;
        #1;
        chk("m0_rdy", 64'(rdy0), 64'h4);
        tick();
        in_valid = 4'h0;
        chk("m0_ov", 64'(ov0), 64'h1);
        chk("m0_od", od0, 64'hDEAD_BEEF_0000_0002);
        chk("m0_os", 64'(os0), 64'h2);
        chk("m0_ol", 64'(ol0), 64'h1);
        tick();

        // Packet lock on channel 1 while sel moves to 3
        sel = 2'd1;
        in_valid = 4'b0010;
        in_last = 4'b0000;
        in_data[1*W +: W] = 64'hA1;
        in_data[3*W +: W] = 64'hC3;
        #1;
        chk("lk_rdy_a1", 64'(rdy0), 64'h2);
        tick();
        sel = 2'd3;
        in_valid = 4'b1000;
        in_last = 4'b1000;
        #1;
        chk("lk_od_a1", od0, 64'hA1);
        chk("lk_bubble_rdy", 64'(rdy0), 64'h0);
        tick();
        chk("lk_bubble_ov", 64'(ov0), 64'h0);
        in_valid = 4'b1010;
        in_data[1*W +: W] = 64'hA2;
        #1;
        chk("lk_rdy_a2", 64'(rdy0), 64'h2);
        tick();
        chk("lk_od_a2", od0, 64'hA2);
        chk("lk_os_a2", 64'(os0), 64'h1);
        chk("lk_ol_a2", 64'(ol0), 64'h0);
        in_data[1*W +: W] = 64'hA3;
        in_last = 4'b1010;
        #1;
        chk("lk_rdy_a3", 64'(rdy0), 64'h2);
        tick();
        chk("lk_od_a3", od0, 64'hA3);
        chk("lk_ol_a3", 64'(ol0), 64'h1);
        in_valid = 4'b1000;
        #1;
        chk("lk_rdy_c3", 64'(rdy0), 64'h8);
        tick();
        chk("lk_od_c3", od0, 64'hC3);
        chk("lk_os_c3", 64'(os0), 64'h3);
        in_valid = 4'h0;
        tick();

        // Round-robin over four always-valid single-beat channels
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 64'h1000 + 64'(i);
        in_valid = 4'hF;
        in_last = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #0;
            chk("rr_rdy", 64'(rdy1), 64'(4'b0001 << (k % 4)));
            tick();
            chk("rr_src", 64'(os1), 64'(k % 4));
            chk("rr_data", od1, 64'h1000 + 64'(k % 4));
        end
        in_valid = 4'h0;
        tick();
        chk("rr_end_ov", 64'(ov1), 64'h0);

        // Backpressure after first beat
        in0 = cnt_in;
        out0 = cnt_out;
        in_valid = 4'hF;
        #0;
        chk("bp_rdy0", 64'(rdy1), 64'h1);
        tick();
        out_ready = 1'b0;
        #1;
        chk("bp_rdy_hold", 64'(rdy1), 64'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_ov", 64'(ov1), 64'h1);
            chk("bp_od", od1, 64'h1000);
            chk("bp_rdy", 64'(rdy1), 64'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_resume", 64'(rdy1), 64'h2);
        tick();
        in_valid = 4'h0;
        chk("bp_src_next", 64'(os1), 64'h1);
        chk("bp_od_next", od1, 64'h1001);
        tick();
        chk("bp_drain_ov", 64'(ov1), 64'h0);
        chk("bp_cnt_in", 64'(cnt_in - in0), 64'd2);
        chk("bp_cnt_out", 64'(cnt_out - out0), 64'd2);

        // Reset in the middle of a channel 2 packet
        in_valid = 4'b0100;
        in_last = 4'b0000;
        in_data[2*W +: W] = 64'h2222;
        #1;
        chk("mr_rdy_b1", 64'(rdy1), 64'h4);
        tick();
        chk("mr_od_b1", od1, 64'h2222);
        reset = 1'b1;
        #1;
        chk("mr_rst_rdy", 64'(rdy1), 64'h0);
        tick();
        reset = 1'b0;
        chk("mr_ov", 64'(ov1), 64'h0);
        in_valid = 4'b0101;
        in_last = 4'hF;
        #1;
        chk("mr_rdy_ch0", 64'(rdy1), 64'h1);
        tick();
        in_valid = 4'h0;
        chk("mr_src_ch0", 64'(os1), 64'h0);
        chk("mr_ov_ch0", 64'(ov1), 64'h1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
